// File: rtl/fetch_pkg.sv
// Shared widths, opcode constants, FSM state and queue payload for the fetch front end.
package fetch_pkg;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned IR_W  = 16;
    localparam int unsigned OPC_W = 3;

    localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [PC_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {IR, PC}; flush wins over push/pop, head reads as zero when empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  fetch_entry_t               i_entry,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output fetch_entry_t               o_head,
    output logic                       o_valid,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    fetch_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic               w_pop;

    assign w_pop = i_pop & (r_count != '0);

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_tail] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_tail <= PTR_W'(r_tail + 1'b1);
            end
            if (w_pop) begin
                r_head <= PTR_W'(r_head + 1'b1);
            end
            if (i_push && !w_pop) begin
                r_count <= CNT_W'(r_count + 1'b1);
            end else if (!i_push && w_pop) begin
                r_count <= CNT_W'(r_count - 1'b1);
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_head  = o_valid ? r_mem[r_head] : '0;

endmodule

// File: rtl/pipeline_fetch.sv
// Instruction-fetch front end: owns the fetch PC, issues credit-limited imem reads,
// queues returned instructions, flushes on redirect and stops after HALT.
module pipeline_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned      DEPTH    = 2,
    parameter logic [PC_W-1:0]  RESET_PC = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            fetch_next_in,
    input  logic            redirect_in,
    input  logic [PC_W-1:0] redirect_pc_in,
    output logic [IR_W-1:0] IR_out,
    output logic [PC_W-1:0] PC_out,
    output logic            valid_out,
    output logic            halted_out
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned CRD_W = CNT_W + 1;

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic [PC_W-1:0]    r_fpc;
    logic [PC_W-1:0]    r_inflight_pc;
    logic               r_inflight;

    logic [CNT_W-1:0]   w_count;
    logic               w_valid;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_pop;
    logic               w_resp;
    logic               w_resp_halt;
    logic               w_credit;
    logic               w_issue;

    assign w_pop       = fetch_next_in & w_valid;
    assign w_resp      = r_inflight & ~redirect_in;
    assign w_resp_halt = w_resp & (imem_rdata[IR_W-1 -: OPC_W] == OPC_HALT);

    // count + inflight - pop < DEPTH, rearranged to stay unsigned.
    assign w_credit = (CRD_W'(w_count) + CRD_W'(r_inflight)) < (CRD_W'(DEPTH) + CRD_W'(w_pop));

    // Gated by rst_n so no request is seen while reset is asserted.
    assign w_issue   = rst_n & (r_state == RUN) & ~redirect_in & ~w_resp_halt & w_credit;
    assign imem_req  = w_issue;
    assign imem_addr = w_issue ? r_fpc : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_in) begin
            w_state_next = RUN;
        end else if (w_resp_halt) begin
            w_state_next = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc         <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (redirect_in) begin
                r_fpc <= redirect_pc_in;
            end else if (w_issue) begin
                r_fpc         <= PC_W'(r_fpc + 1'b1);
                r_inflight_pc <= r_fpc;
            end
        end
    end

    assign w_push_entry = '{ir: imem_rdata, pc: r_inflight_pc};

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_resp),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_in),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign IR_out     = w_head.ir;
    assign PC_out     = w_head.pc;
    assign valid_out  = w_valid;
    assign halted_out = (r_state == HALT);

endmodule

// File: doc/pipeline_fetch.md
# pipeline_fetch

Instruction-fetch front end feeding the decode stage's `IR_in`/`PC_in`. It owns the fetch PC, issues one-cycle-latency reads to instruction memory, and buffers returned instructions with their PCs in a 2-entry queue. It applies back-pressure from the pipeline's `fetch_next` handshake, flushes on a delayed-branch redirect from the writeback stage, and stops fetching after a HALT opcode.

## Interface
- `PC_W`, 8, fetch PC / imem address width
- `IR_W`, 16, instruction width
- `DEPTH`, 2, instruction queue entries (power of two, ≥2)
- `RESET_PC`, 8'h00, PC fetched first after reset
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `imem_req`  out  1  read request this cycle
- `imem_addr`  out  PC_W  read address, valid when `imem_req`
- `imem_rdata`  in  IR_W  read data, valid exactly one cycle after `imem_req`
- `fetch_next_in`  in  1  downstream consumes the head entry this cycle
- `redirect_in`  in  1  delayed branch taken (from `do_delayed_B_4out`)
- `redirect_pc_in`  in  PC_W  target PC (low bits of `delayed_B_4out`)
- `IR_out`  out  IR_W  head instruction; 0 when `valid_out`=0
- `PC_out`  out  PC_W  PC of head instruction; 0 when `valid_out`=0
- `valid_out`  out  1  queue non-empty
- `halted_out`  out  1  state is HALT

## Operation
- State: `fpc` (next fetch PC), queue (IR+PC per entry, head/tail pointers, count), `inflight` flag + `inflight_pc`, FSM {RUN, HALT}.
- `pop` = `fetch_next_in & valid_out`; `fetch_next_in` on empty queue is ignored.
- `resp` = `inflight` and not killed; `resp_halt` = `resp & imem_rdata[15:13]==3'b111`.
- Issue: `imem_req` = RUN & !`redirect_in` & !`resp_halt` & (count + inflight − pop < DEPTH). On issue: `imem_addr`=`fpc`, `inflight_pc`<=`fpc`, `fpc`<=`fpc`+1 (mod 2^PC_W, FF wraps to 00).
- Response: when `resp`, {`imem_rdata`, `inflight_pc`} written at tail. Credit rule guarantees no overflow; push and pop in the same cycle leave count unchanged.
- HALT: `resp_halt` → HALT next cycle; the HALT instruction is still queued and delivered. No requests in HALT. Queue keeps draining via `pop`.
- Redirect (highest priority): queue emptied, in-flight response discarded (next-cycle `imem_rdata` ignored), `fpc`<=`redirect_pc_in`, FSM→RUN (also from HALT), no request that cycle, `pop` in the same cycle has no effect beyond the flush.
- Reset (`rst_n`=0, async): `fpc`=RESET_PC, queue empty, `inflight`=0, FSM=RUN; outputs `imem_req`=0, `imem_addr`=0, `valid_out`=0, `IR_out`=0, `PC_out`=0, `halted_out`=0. Reset mid-fetch discards all state.

## Timing
- Cycle 0 after reset release: `imem_req`=1, addr RESET_PC. Cycle 1: data arrives, written at end of cycle. Cycle 2: `valid_out`=1. Request-to-valid latency 2 cycles.
- Sustained throughput: 1 instruction/cycle with `fetch_next_in` held high and DEPTH=2.
- Redirect in cycle t: first request at target in t+1, `valid_out` at t+3; `valid_out`=0 in t+1, t+2.
- `imem_req`/`imem_addr` combinational from registered state plus `redirect_in`, `fetch_next_in`, `imem_rdata` opcode bits; all other outputs registered/queue-driven.

## Structure
- Shared package `fetch_pkg`: `PC_W`, `IR_W`, `OPC_HALT`=3'b111, `fetch_state_t` enum {RUN, HALT}.
- Sub-module `fetch_queue`: parameterised DEPTH-entry FIFO of {IR, PC} with push, pop, flush, count; async active-low reset.
- Top holds `fpc`, in-flight tracking, FSM, credit logic.

## Test plan
- Reset release, `fetch_next_in`=1, imem[i]=16'h1000+i → `PC_out` 00,01,02… and `IR_out` 1000,1001,… from cycle 2, one per cycle, no gaps.
- `fetch_next_in`=0 for 5 cycles → queue fills to 2, `imem_req`=0 after 2 issued; resume → head PC 00 then 01, no loss/duplication.
- Redirect to 8'h40 while queue holds 2 and one in flight → `valid_out`=0 for 2 cycles, next `PC_out`=40, stale data never appears.
- imem[05]=16'hE000 (HALT) → entries 00–05 delivered, `halted_out`=1, no requests after addr 05; redirect to 10 → RUN, `PC_out`=10.
- `fpc`=FE, free-running → PCs FE, FF, 00, 01.
- Assert `rst_n`=0 mid-stream between edges → all outputs 0 immediately; restart fetches RESET_PC.
